imem_fetch_unit: RTL

Parametrised, synchronous instruction memory for the RV64I fetch stage. It replaces a combinational word-indexed ROM with a registered-read memory that has a valid/ready request/response handshake, a loader write port, and a post-reset fill sequencer. On exit from reset it fills every word with a NOP. Optional fault checking flags misaligned and out-of-range fetches.

---
 rtl/imem_fetch_unit_if.sv | 27 ++
 rtl/imem_fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/imem_fetch_unit_if.sv
// rtl/imem_fetch_unit_if.sv - fetch request/response and loader write bundle for imem_fetch_unit
interface imem_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_fault;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Fetch stage / loader side
  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  // Memory side
  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - registered-read instruction memory with post-reset NOP fill; optional IMEM_FAULT_EN fault checking
module imem_fetch_unit #(
  parameter int          DEPTH  = 256,
  parameter int          ADDR_W = 64,
  parameter logic [31:0] FILL   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_unit_if.slave  bus,
  output logic              init_done
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              req_ready;
  logic              req_fault;
  logic              wr_fault;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign req_idx = bus.req_addr[2 +: IDX_W];
  assign wr_idx  = bus.wr_addr[2 +: IDX_W];

  // Bits outside the word index only matter when fault checking is built in
  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[1:0],
                              bus.wr_addr[ADDR_W-1:IDX_W+2], bus.wr_addr[1:0]};

`ifdef IMEM_FAULT_EN
  assign req_fault = (|bus.req_addr[1:0]) | (|bus.req_addr[ADDR_W-1:IDX_W+2]);
  assign wr_fault  = (|bus.wr_addr[1:0])  | (|bus.wr_addr[ADDR_W-1:IDX_W+2]);
`else
  assign req_fault = 1'b0;
  assign wr_fault  = 1'b0;
`endif

  assign init_done     = (state_q == S_READY);
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;

  // Storage array: fill sequencer owns the write port until READY; never cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem[fill_cnt_q] <= FILL;
      end else if (bus.wr_en && !wr_fault) begin
        mem[wr_idx] <= bus.wr_data;
      end
    end
  end

  // State, fill counter and response register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      fill_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Next state, acceptance and response capture (the read sees the pre-write word)
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    req_ready   = 1'b0;

    case (state_q)
      S_INIT: begin
        fill_cnt_d = fill_cnt_q + IDX_W'(1);
        if (fill_cnt_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        req_ready = !rsp_valid_q || bus.rsp_ready;
      end
      default: state_d = S_INIT;
    endcase

    if (bus.req_valid && req_ready) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = req_fault ? FILL : mem[req_idx];
      rsp_fault_d = req_fault;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end
endmodule
